// File: rtl/motor_output_interlock.sv
// Two-motor contactor interlock: break-before-make dead time between motors,
// latched fault handling, and per-motor run-time seconds counters.
module motor_output_interlock #(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned DEAD_MS = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_m1,
   input  logic        req_m2,
   input  logic        fault,
   input  logic        fault_clr,
   output logic        m1_out,
   output logic        m2_out,
   output logic        dead_busy,
   output logic        fault_lat,
   output logic        conflict,
   output logic [31:0] m1_secs,
   output logic [31:0] m2_secs
);

   localparam int unsigned DEAD_CYC = (CLK_HZ / 1000) * DEAD_MS;
   localparam int unsigned SEC_CYC  = CLK_HZ;
   localparam int unsigned DW       = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
   localparam int unsigned PW       = (SEC_CYC > 1) ? $clog2(SEC_CYC) : 1;
   localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYC - 1);
   localparam logic [PW-1:0] PRE_MAX   = PW'(SEC_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN_M1,
      S_RUN_M2,
      S_DEAD,
      S_FAULT
   } state_t;

   state_t          r_state;
   state_t          w_idle_next;
   logic [DW-1:0]   r_dead_cnt;
   logic [PW-1:0]   r_pre_m1;
   logic [PW-1:0]   r_pre_m2;
   logic [31:0]     r_m1_secs;
   logic [31:0]     r_m2_secs;
   logic            r_conflict;
   logic            w_m1_req;
   logic            w_m2_req;

   assign w_m1_req = req_m1 & ~req_m2;
   assign w_m2_req = req_m2 & ~req_m1;

   // Request evaluation shared by IDLE and the DEAD exit edge
   always_comb begin
      w_idle_next = S_IDLE;
      if (w_m1_req)
         w_idle_next = S_RUN_M1;
      else if (w_m2_req)
         w_idle_next = S_RUN_M2;
   end

   // Interlock state machine; fault overrides everything except reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_dead_cnt <= '0;
      end else if (fault) begin
         r_state <= S_FAULT;
      end else begin
         case (r_state)
            S_IDLE: r_state <= w_idle_next;
            S_RUN_M1: begin
               if (!w_m1_req) begin
                  r_state    <= S_DEAD;
                  r_dead_cnt <= DEAD_LOAD;
               end
            end
            S_RUN_M2: begin
               if (!w_m2_req) begin
                  r_state    <= S_DEAD;
                  r_dead_cnt <= DEAD_LOAD;
               end
            end
            S_DEAD: begin
               // Counter runs DEAD_LOAD..0, giving exactly DEAD_CYC cycles in DEAD
               if (r_dead_cnt == '0)
                  r_state <= w_idle_next;
               else
                  r_dead_cnt <= r_dead_cnt - 1'b1;
            end
            S_FAULT: begin
               if (fault_clr) begin
                  r_state    <= S_DEAD;
                  r_dead_cnt <= DEAD_LOAD;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Registered AND of both requests, independent of state
   always_ff @(posedge clk) begin
      if (rst)
         r_conflict <= 1'b0;
      else
         r_conflict <= req_m1 & req_m2;
   end

   // Motor 1 run-time prescaler and saturating seconds counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre_m1  <= '0;
         r_m1_secs <= '0;
      end else if (r_state == S_RUN_M1) begin
         if (r_pre_m1 == PRE_MAX) begin
            r_pre_m1 <= '0;
            if (r_m1_secs != '1)
               r_m1_secs <= r_m1_secs + 32'd1;
         end else begin
            r_pre_m1 <= r_pre_m1 + 1'b1;
         end
      end
   end

   // Motor 2 run-time prescaler and saturating seconds counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre_m2  <= '0;
         r_m2_secs <= '0;
      end else if (r_state == S_RUN_M2) begin
         if (r_pre_m2 == PRE_MAX) begin
            r_pre_m2 <= '0;
            if (r_m2_secs != '1)
               r_m2_secs <= r_m2_secs + 32'd1;
         end else begin
            r_pre_m2 <= r_pre_m2 + 1'b1;
         end
      end
   end

   // Moore outputs decoded from the registered state only
   assign m1_out    = (r_state == S_RUN_M1);
   assign m2_out    = (r_state == S_RUN_M2);
   assign dead_busy = (r_state == S_DEAD);
   assign fault_lat = (r_state == S_FAULT);
   assign conflict  = r_conflict;
   assign m1_secs   = r_m1_secs;
   assign m2_secs   = r_m2_secs;

endmodule

// File: tb/tb_motor_output_interlock.sv
// Directed bench for motor_output_interlock with CLK_HZ=1000, DEAD_MS=200:
// DEAD_CYC=200 and one second = 1000 cycles.
module tb_motor_output_interlock;

   logic        clk;
   logic        rst;
   logic        req_m1;
   logic        req_m2;
   logic        fault;
   logic        fault_clr;
   logic        m1_out;
   logic        m2_out;
   logic        dead_busy;
   logic        fault_lat;
   logic        conflict;
   logic [31:0] m1_secs;
   logic [31:0] m2_secs;

   int unsigned n_pass  = 0;
   int unsigned n_fail  = 0;
   int unsigned n_total = 0;
   int unsigned n_both  = 0;

   motor_output_interlock #(
      .CLK_HZ  (1000),
      .DEAD_MS (200)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_m1    (req_m1),
      .req_m2    (req_m2),
      .fault     (fault),
      .fault_clr (fault_clr),
      .m1_out    (m1_out),
      .m2_out    (m2_out),
      .dead_busy (dead_busy),
      .fault_lat (fault_lat),
      .conflict  (conflict),
      .m1_secs   (m1_secs),
      .m2_secs   (m2_secs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Both contactors energised together is never allowed
   always @(negedge clk) begin
      if (m1_out && m2_out)
         n_both++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; req_m1 = 1'b0; req_m2 = 1'b0; fault = 1'b0; fault_clr = 1'b0;
      tick(2);
      chk1 ("rst_m1_out", m1_out, 1'b0);
      chk1 ("rst_m2_out", m2_out, 1'b0);
      chk1 ("rst_dead", dead_busy, 1'b0);
      chk1 ("rst_fault", fault_lat, 1'b0);
      chk1 ("rst_conflict", conflict, 1'b0);
      chk32("rst_m1_secs", m1_secs, 32'd0);
      chk32("rst_m2_secs", m2_secs, 32'd0);

      // Reset overrides fault and requests
      fault = 1'b1; req_m1 = 1'b1; req_m2 = 1'b1;
      tick(1);
      chk1 ("rst_over_fault", fault_lat, 1'b0);
      chk1 ("rst_over_conflict", conflict, 1'b0);
      chk1 ("rst_over_m1", m1_out, 1'b0);
      fault = 1'b0; req_m2 = 1'b0;

      // Release with M1 requested: output one cycle later, then 3 s of run
      rst = 1'b0;
      tick(1);
      chk1 ("m1_start", m1_out, 1'b1);
      tick(2999);
      chk32("m1_secs_2", m1_secs, 32'd2);
      tick(1);
      chk32("m1_secs_3", m1_secs, 32'd3);
      chk32("m2_secs_0", m2_secs, 32'd0);

      // Switch to M2: full dead time then M2
      req_m1 = 1'b0; req_m2 = 1'b1;
      tick(1);
      chk1 ("sw_m1_off", m1_out, 1'b0);
      chk1 ("sw_dead_on", dead_busy, 1'b1);
      tick(199);
      chk1 ("sw_dead_last", dead_busy, 1'b1);
      chk1 ("sw_m2_still_off", m2_out, 1'b0);
      tick(1);
      chk1 ("sw_dead_off", dead_busy, 1'b0);
      chk1 ("sw_m2_on", m2_out, 1'b1);

      // Both requests in RUN_M2: conflict, DEAD, then IDLE
      req_m1 = 1'b1;
      tick(1);
      chk1 ("cf_conflict", conflict, 1'b1);
      chk1 ("cf_dead", dead_busy, 1'b1);
      chk1 ("cf_m2_off", m2_out, 1'b0);
      tick(199);
      chk1 ("cf_dead_last", dead_busy, 1'b1);
      tick(1);
      chk1 ("cf_idle_dead", dead_busy, 1'b0);
      chk1 ("cf_idle_m1", m1_out, 1'b0);
      chk1 ("cf_idle_m2", m2_out, 1'b0);
      chk1 ("cf_persist", conflict, 1'b1);
      tick(1);
      chk1 ("cf_stay_idle", m1_out | m2_out | dead_busy, 1'b0);
      chk32("cf_m2_secs", m2_secs, 32'd0);

      // Fault during DEAD, ignored clear while fault high, then clean clear
      req_m2 = 1'b0;
      tick(1);
      chk1 ("fd_m1_on", m1_out, 1'b1);
      chk1 ("fd_conflict_clr", conflict, 1'b0);
      req_m1 = 1'b0;
      tick(1);
      chk1 ("fd_dead", dead_busy, 1'b1);
      tick(10);
      fault = 1'b1;
      tick(1);
      chk1 ("fd_fault_lat", fault_lat, 1'b1);
      chk1 ("fd_dead_abort", dead_busy, 1'b0);
      fault_clr = 1'b1;
      tick(1);
      chk1 ("fd_clr_ignored", fault_lat, 1'b1);
      fault_clr = 1'b0; fault = 1'b0; req_m1 = 1'b1;
      tick(3);
      chk1 ("fd_hold_no_clr", fault_lat, 1'b1);
      chk1 ("fd_hold_m1_off", m1_out, 1'b0);
      fault_clr = 1'b1;
      tick(1);
      chk1 ("fd_clr_dead", dead_busy, 1'b1);
      chk1 ("fd_clr_unlatched", fault_lat, 1'b0);
      fault_clr = 1'b0;
      tick(199);
      chk1 ("fd_dead_last", dead_busy, 1'b1);
      chk1 ("fd_m1_wait", m1_out, 1'b0);
      tick(1);
      chk1 ("fd_m1_restart", m1_out, 1'b1);

      // Reset at cycle 50 of DEAD abandons the dead time
      req_m1 = 1'b0;
      tick(1);
      chk1 ("rd_dead", dead_busy, 1'b1);
      tick(49);
      rst = 1'b1;
      tick(1);
      chk1 ("rd_dead_clr", dead_busy, 1'b0);
      chk32("rd_m1_secs", m1_secs, 32'd0);
      rst = 1'b0; req_m2 = 1'b1;
      tick(1);
      chk1 ("rd_m2_immediate", m2_out, 1'b1);

      // Fault on the same edge as a prescaler wrap still counts the second
      tick(999);
      chk32("fw_before", m2_secs, 32'd0);
      fault = 1'b1;
      tick(1);
      chk32("fw_counted", m2_secs, 32'd1);
      chk1 ("fw_fault", fault_lat, 1'b1);
      chk1 ("fw_m2_off", m2_out, 1'b0);
      fault = 1'b0; fault_clr = 1'b1; req_m2 = 1'b0; req_m1 = 1'b1;
      tick(1);
      fault_clr = 1'b0;
      tick(200);
      chk1 ("sat_m1_on", m1_out, 1'b1);
      chk32("fw_m2_hold", m2_secs, 32'd1);

      // Saturation: preload near the top and run two more seconds
      force dut.r_m1_secs = 32'hFFFF_FFFE;
      #1;
      release dut.r_m1_secs;
      tick(1000);
      chk32("sat_reach", m1_secs, 32'hFFFF_FFFF);
      tick(1000);
      chk32("sat_hold", m1_secs, 32'hFFFF_FFFF);

      chk32("never_both", n_both, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/motor_output_interlock.md
MOTOR_OUTPUT_INTERLOCK -- requirements
Module: motor_output_interlock

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, clock frequency in Hz.
REQ-002 The block SHALL have parameter DEAD_MS, default 500, break-before-make dead time in ms (>=1).
REQ-003 The block SHALL derive DEAD_CYC = (CLK_HZ/1000)*DEAD_MS and SEC_CYC = CLK_HZ, both >=1.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 req_m1  in  1  upstream alternation controller requests motor 1 energised.
REQ-007 req_m2  in  1  upstream alternation controller requests motor 2 energised.
REQ-008 fault  in  1  synchronised overload/trip input, active-high.
REQ-009 fault_clr  in  1  single-cycle debounced clear pulse, active-high.
REQ-010 m1_out  out  1  motor 1 contactor drive.
REQ-011 m2_out  out  1  motor 2 contactor drive.
REQ-012 dead_busy  out  1  high while in DEAD.
REQ-013 fault_lat  out  1  high while in FAULT.
REQ-014 conflict  out  1  registered flag, high the cycle after req_m1 and req_m2 were both sampled high.
REQ-015 m1_secs  out  32  accumulated motor 1 run time in seconds.
REQ-016 m2_secs  out  32  accumulated motor 2 run time in seconds.

Function
REQ-017 The block SHALL implement FSM states IDLE, RUN_M1, RUN_M2, DEAD, FAULT; outputs SHALL be decoded from the registered state only (Moore).
REQ-018 m1_out SHALL be 1 only in RUN_M1, m2_out only in RUN_M2; both outputs high together SHALL be impossible in every state.
REQ-019 Valid request: M1 = req_m1 & ~req_m2; M2 = req_m2 & ~req_m1; neither/both = no valid request.
REQ-020 IDLE: M1 -> RUN_M1, M2 -> RUN_M2, else stay; latency request-sampled edge to output high = 1 cycle.
REQ-021 RUN_M1: stay while M1 valid; any other request (M2, none, both) -> DEAD.
REQ-022 RUN_M2: symmetric to REQ-021.
REQ-023 DEAD: a down-counter SHALL load DEAD_CYC-1 on entry and decrement each cycle; the FSM SHALL remain in DEAD for exactly DEAD_CYC cycles, then evaluate requests as in IDLE on that exit edge.
REQ-024 Requests changing during DEAD SHALL NOT shorten or restart the dead time.
REQ-025 fault=1 sampled in any state SHALL force FAULT on that edge (priority over all requests and DEAD); outputs low the following cycle.
REQ-026 FAULT: exit only when fault_clr=1 and fault=0 in the same cycle -> DEAD (full dead time before any restart); fault_clr while fault=1 SHALL be ignored.
REQ-027 conflict SHALL update every cycle as the registered AND of req_m1 and req_m2, independent of state.
REQ-028 Each motor SHALL have its own prescaler (0..SEC_CYC-1) advancing only in its RUN state and holding its value otherwise.
REQ-029 When a prescaler wraps from SEC_CYC-1 to 0, the corresponding seconds counter SHALL increment by 1, saturating at 32'hFFFF_FFFF.
REQ-030 Simultaneous fault and prescaler wrap on the same edge SHALL still count that second.

Reset
REQ-031 rst=1 sampled SHALL force state IDLE, DEAD counter 0, both prescalers 0, m1_secs=m2_secs=0, conflict=0, all outputs 0, overriding fault and requests.
REQ-032 Reset asserted mid-DEAD or mid-RUN SHALL abandon the dead time; after release a valid request energises its motor 1 cycle later (no dead time from reset).

Verification (CLK_HZ=100_000, DEAD_MS=2 -> DEAD_CYC=200, SEC_CYC=100_000)
REQ-033 Release rst, req_m1=1 -> m1_out=1 one cycle later; after 300_000 cycles m1_secs=3, m2_secs=0.
REQ-034 In RUN_M1 switch to req_m2=1/req_m1=0 -> m1_out=0 next cycle, dead_busy=1 for exactly 200 cycles, m2_out=1 on the following cycle, never both high.
REQ-035 Both requests high in RUN_M2 -> conflict=1 next cycle, DEAD entered, after 200 cycles IDLE with both outputs 0 while conflict persists.
REQ-036 fault=1 during DEAD -> FAULT next edge, fault_lat=1; fault_clr with fault=1 ignored; fault=0 plus fault_clr -> 200-cycle DEAD, then req_m1 restarts M1.
REQ-037 rst pulse at cycle 50 of DEAD -> all outputs and counters 0; next valid request energises after 1 cycle without dead time.
REQ-038 Preload m1_secs near 32'hFFFF_FFFF via forced run -> counter holds at 32'hFFFF_FFFF, no wrap.
